// File: rtl/mips_multicycle_ctrl.sv
// Multicycle control sequencer for the MIPS datapath.
// Walks each instruction through fetch/decode/execute/memory/writeback
// states, drives every datapath select and write enable, waits on the
// memory ready handshake and traps on illegal opcodes or memory timeouts.
module mips_multicycle_ctrl #(
  parameter int OPW      = 6,
  parameter int WAIT_MAX = 16,
  parameter int CNTW     = 32
) (
  input  logic            clk,
  input  logic            clr,
  input  logic [OPW-1:0]  opcode,
  input  logic            mem_ready,
  output logic            pc_write,
  output logic            pc_write_cond,
  output logic [1:0]      pc_source,
  output logic            i_or_d,
  output logic            mem_read,
  output logic            mem_write,
  output logic            ir_write,
  output logic            reg_dst,
  output logic            mem_to_reg,
  output logic            reg_write,
  output logic            alu_src_a,
  output logic [1:0]      alu_src_b,
  output logic [1:0]      alu_op,
  output logic            instr_done,
  output logic [CNTW-1:0] retired,
  output logic            trap,
  output logic [1:0]      trap_cause
);

  // State encoding (4-bit); 13..15 are unused and fall into TRAP.
  localparam logic [3:0] S_FETCH  = 4'd0;
  localparam logic [3:0] S_DECODE = 4'd1;
  localparam logic [3:0] S_ADDR   = 4'd2;
  localparam logic [3:0] S_MEM_RD = 4'd3;
  localparam logic [3:0] S_MEM_WB = 4'd4;
  localparam logic [3:0] S_MEM_WR = 4'd5;
  localparam logic [3:0] S_R_EXEC = 4'd6;
  localparam logic [3:0] S_R_WB   = 4'd7;
  localparam logic [3:0] S_I_EXEC = 4'd8;
  localparam logic [3:0] S_I_WB   = 4'd9;
  localparam logic [3:0] S_BRANCH = 4'd10;
  localparam logic [3:0] S_JUMP   = 4'd11;
  localparam logic [3:0] S_TRAP   = 4'd12;

  localparam logic [OPW-1:0] OP_RTYPE = OPW'(6'b000000);
  localparam logic [OPW-1:0] OP_LW    = OPW'(6'b100011);
  localparam logic [OPW-1:0] OP_SW    = OPW'(6'b101011);
  localparam logic [OPW-1:0] OP_BEQ   = OPW'(6'b000100);
  localparam logic [OPW-1:0] OP_J     = OPW'(6'b000010);
  localparam logic [OPW-1:0] OP_ADDI  = OPW'(6'b001000);

  localparam logic [1:0] CAUSE_NONE    = 2'd0;
  localparam logic [1:0] CAUSE_ILLEGAL = 2'd1;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'd2;

  // Stall counter only needs to reach WAIT_MAX-1: the WAIT_MAX-th
  // unanswered cycle is the one that triggers the timeout.
  localparam int SW = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;
  localparam logic [SW-1:0] STALL_LAST = SW'(WAIT_MAX - 1);

  logic [3:0]      r_state;
  logic [SW-1:0]   r_stall;
  logic            r_trap;
  logic [1:0]      r_cause;
  logic [CNTW-1:0] r_retired;
  logic            r_is_store;

  logic [3:0] w_state_next;
  logic [1:0] w_cause_next;
  logic       w_mem_state;
  logic       w_waiting;
  logic       w_timeout;

  logic       w_pc_write;
  logic       w_pc_write_cond;
  logic [1:0] w_pc_source;
  logic       w_i_or_d;
  logic       w_mem_read;
  logic       w_mem_write;
  logic       w_ir_write;
  logic       w_reg_dst;
  logic       w_mem_to_reg;
  logic       w_reg_write;
  logic       w_alu_src_a;
  logic [1:0] w_alu_src_b;
  logic [1:0] w_alu_op;
  logic       w_instr_done;

  assign w_mem_state = (r_state == S_FETCH) || (r_state == S_MEM_RD) ||
                       (r_state == S_MEM_WR);
  assign w_waiting   = w_mem_state && !mem_ready;
  assign w_timeout   = w_waiting && (r_stall == STALL_LAST);

  // Next-state selection, with the memory timeout overriding the hold.
  always_comb begin
    w_state_next = r_state;
    w_cause_next = CAUSE_NONE;
    case (r_state)
      S_FETCH:  if (mem_ready) w_state_next = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_RTYPE:     w_state_next = S_R_EXEC;
          OP_LW, OP_SW: w_state_next = S_ADDR;
          OP_BEQ:       w_state_next = S_BRANCH;
          OP_J:         w_state_next = S_JUMP;
          OP_ADDI:      w_state_next = S_I_EXEC;
          default: begin
            w_state_next = S_TRAP;
            w_cause_next = CAUSE_ILLEGAL;
          end
        endcase
      end
      S_ADDR:   w_state_next = r_is_store ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD: if (mem_ready) w_state_next = S_MEM_WB;
      S_MEM_WR: if (mem_ready) w_state_next = S_FETCH;
      S_R_EXEC: w_state_next = S_R_WB;
      S_I_EXEC: w_state_next = S_I_WB;
      S_MEM_WB, S_R_WB, S_I_WB, S_BRANCH, S_JUMP: w_state_next = S_FETCH;
      S_TRAP:   w_state_next = S_TRAP;
      default: begin
        w_state_next = S_TRAP;
        w_cause_next = CAUSE_ILLEGAL;
      end
    endcase
    if (w_timeout) begin
      w_state_next = S_TRAP;
      w_cause_next = CAUSE_TIMEOUT;
    end
  end

  // Moore decode of the control word; only fetch strobes and the store
  // completion pulse look at mem_ready.
  always_comb begin
    w_pc_write      = 1'b0;
    w_pc_write_cond = 1'b0;
    w_pc_source     = 2'd0;
    w_i_or_d        = 1'b0;
    w_mem_read      = 1'b0;
    w_mem_write     = 1'b0;
    w_ir_write      = 1'b0;
    w_reg_dst       = 1'b0;
    w_mem_to_reg    = 1'b0;
    w_reg_write     = 1'b0;
    w_alu_src_a     = 1'b0;
    w_alu_src_b     = 2'd0;
    w_alu_op        = 2'd0;
    w_instr_done    = 1'b0;
    case (r_state)
      S_FETCH: begin
        w_mem_read  = 1'b1;
        w_alu_src_b = 2'd1;
        w_ir_write  = mem_ready;
        w_pc_write  = mem_ready;
      end
      S_DECODE: w_alu_src_b = 2'd3;
      S_ADDR, S_I_EXEC: begin
        w_alu_src_a = 1'b1;
        w_alu_src_b = 2'd2;
      end
      S_MEM_RD: begin
        w_mem_read = 1'b1;
        w_i_or_d   = 1'b1;
      end
      S_MEM_WB: begin
        w_reg_write  = 1'b1;
        w_mem_to_reg = 1'b1;
        w_instr_done = 1'b1;
      end
      S_MEM_WR: begin
        w_mem_write  = 1'b1;
        w_i_or_d     = 1'b1;
        w_instr_done = mem_ready;
      end
      S_R_EXEC: begin
        w_alu_src_a = 1'b1;
        w_alu_op    = 2'b10;
      end
      S_R_WB: begin
        w_reg_write  = 1'b1;
        w_reg_dst    = 1'b1;
        w_instr_done = 1'b1;
      end
      S_I_WB: begin
        w_reg_write  = 1'b1;
        w_instr_done = 1'b1;
      end
      S_BRANCH: begin
        w_alu_src_a     = 1'b1;
        w_alu_op        = 2'b01;
        w_pc_write_cond = 1'b1;
        w_pc_source     = 2'd1;
        w_instr_done    = 1'b1;
      end
      S_JUMP: begin
        w_pc_write   = 1'b1;
        w_pc_source  = 2'd2;
        w_instr_done = 1'b1;
      end
      default: ;
    endcase
  end

  // State, stall counter, sticky trap and retired counter.
  always_ff @(posedge clk) begin
    if (clr) begin
      r_state    <= S_FETCH;
      r_stall    <= '0;
      r_trap     <= 1'b0;
      r_cause    <= CAUSE_NONE;
      r_retired  <= '0;
      r_is_store <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_stall <= (w_waiting && !w_timeout) ? r_stall + SW'(1) : '0;
      if ((w_state_next == S_TRAP) && (r_state != S_TRAP)) begin
        r_trap  <= 1'b1;
        r_cause <= w_cause_next;
      end
      if (w_instr_done) r_retired <= r_retired + CNTW'(1);
      // Load/store direction is captured once so ADDR does not depend on
      // the opcode still being held.
      if (r_state == S_DECODE) r_is_store <= (opcode == OP_SW);
    end
  end

  // Everything is held low while clr is asserted, so a reset mid-access
  // drops strobes in the same cycle.
  assign pc_write      = w_pc_write      & ~clr;
  assign pc_write_cond = w_pc_write_cond & ~clr;
  assign pc_source     = clr ? 2'd0 : w_pc_source;
  assign i_or_d        = w_i_or_d        & ~clr;
  assign mem_read      = w_mem_read      & ~clr;
  assign mem_write     = w_mem_write     & ~clr;
  assign ir_write      = w_ir_write      & ~clr;
  assign reg_dst       = w_reg_dst       & ~clr;
  assign mem_to_reg    = w_mem_to_reg    & ~clr;
  assign reg_write     = w_reg_write     & ~clr;
  assign alu_src_a     = w_alu_src_a     & ~clr;
  assign alu_src_b     = clr ? 2'd0 : w_alu_src_b;
  assign alu_op        = clr ? 2'd0 : w_alu_op;
  assign instr_done    = w_instr_done    & ~clr;
  assign retired       = clr ? '0 : r_retired;
  assign trap          = r_trap & ~clr;
  assign trap_cause    = clr ? CAUSE_NONE : r_cause;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Self-checking bench for mips_multicycle_ctrl. Instructions are expanded
// into an expected per-cycle control trace from the instruction-level
// behaviour table, then played against the DUT with random memory delays.
module tb_mips_multicycle_ctrl;

  localparam int CNTW     = 4;
  localparam int WAIT_MAX = 16;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic [1:0] pc_source;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       instr_done;
  } ctl_t;

  typedef struct packed {
    ctl_t       c;
    logic       rdy;
    logic [5:0] op;
  } cyc_t;

  logic            clk = 1'b0;
  logic            clr = 1'b1;
  logic [5:0]      opcode = 6'd0;
  logic            mem_ready = 1'b0;
  logic            pc_write, pc_write_cond, i_or_d, mem_read, mem_write;
  logic            ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a;
  logic            instr_done, trap;
  logic [1:0]      pc_source, alu_src_b, alu_op, trap_cause;
  logic [CNTW-1:0] retired;
  ctl_t            dut_ctl;

  int              n_cmp = 0;
  int              n_bad = 0;
  logic [CNTW-1:0] exp_ret;
  cyc_t            plan[$];

  mips_multicycle_ctrl #(.OPW(6), .WAIT_MAX(WAIT_MAX), .CNTW(CNTW)) dut (
    .clk(clk), .clr(clr), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .pc_source(pc_source),
    .i_or_d(i_or_d), .mem_read(mem_read), .mem_write(mem_write),
    .ir_write(ir_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_op(alu_op), .instr_done(instr_done), .retired(retired),
    .trap(trap), .trap_cause(trap_cause)
  );

  assign dut_ctl = {pc_write, pc_write_cond, pc_source, i_or_d, mem_read,
                    mem_write, ir_write, reg_dst, mem_to_reg, reg_write,
                    alu_src_a, alu_src_b, alu_op, instr_done};

  always #5 clk = ~clk;

  function automatic bit is_legal(logic [5:0] op);
    return op == OP_R || op == OP_LW || op == OP_SW || op == OP_BEQ ||
           op == OP_J || op == OP_ADDI;
  endfunction

  function automatic logic [5:0] pick_legal();
    case ($urandom_range(0, 5))
      0: return OP_R;
      1: return OP_LW;
      2: return OP_SW;
      3: return OP_BEQ;
      4: return OP_J;
      default: return OP_ADDI;
    endcase
  endfunction

  function automatic ctl_t fetch_wait_word();
    ctl_t c;
    c = '0;
    c.mem_read  = 1'b1;
    c.alu_src_b = 2'd1;
    return c;
  endfunction

  task automatic add(ctl_t c, logic rdy, logic [5:0] op);
    cyc_t e;
    e.c = c; e.rdy = rdy; e.op = op;
    plan.push_back(e);
  endtask

  // Expected trace of one instruction: fd fetch stalls, md memory stalls.
  task automatic plan_instr(logic [5:0] op, int fd, int md);
    ctl_t c;
    c = fetch_wait_word();
    for (int i = 0; i < fd; i++) add(c, 1'b0, 6'($urandom));
    c.ir_write = 1'b1; c.pc_write = 1'b1;
    add(c, 1'b1, 6'($urandom));
    c = '0; c.alu_src_b = 2'd3;
    add(c, 1'($urandom), op);
    case (op)
      OP_R: begin
        c = '0; c.alu_src_a = 1'b1; c.alu_op = 2'b10;
        add(c, 1'($urandom), op);
        c = '0; c.reg_write = 1'b1; c.reg_dst = 1'b1; c.instr_done = 1'b1;
        add(c, 1'($urandom), op);
      end
      OP_LW, OP_SW: begin
        c = '0; c.alu_src_a = 1'b1; c.alu_src_b = 2'd2;
        add(c, 1'($urandom), op);
        c = '0; c.i_or_d = 1'b1;
        if (op == OP_LW) c.mem_read = 1'b1;
        else c.mem_write = 1'b1;
        for (int i = 0; i < md; i++) add(c, 1'b0, op);
        if (op == OP_SW) c.instr_done = 1'b1;
        add(c, 1'b1, op);
        if (op == OP_LW) begin
          c = '0; c.reg_write = 1'b1; c.mem_to_reg = 1'b1; c.instr_done = 1'b1;
          add(c, 1'($urandom), op);
        end
      end
      OP_BEQ: begin
        c = '0; c.alu_src_a = 1'b1; c.alu_op = 2'b01; c.pc_write_cond = 1'b1;
        c.pc_source = 2'd1; c.instr_done = 1'b1;
        add(c, 1'($urandom), op);
      end
      OP_J: begin
        c = '0; c.pc_write = 1'b1; c.pc_source = 2'd2; c.instr_done = 1'b1;
        add(c, 1'($urandom), op);
      end
      OP_ADDI: begin
        c = '0; c.alu_src_a = 1'b1; c.alu_src_b = 2'd2;
        add(c, 1'($urandom), op);
        c = '0; c.reg_write = 1'b1; c.instr_done = 1'b1;
        add(c, 1'($urandom), op);
      end
      default: ;
    endcase
  endtask

  // Plays the expected trace; entered and left just after a rising edge.
  task automatic run_plan(string tag);
    cyc_t e;
    while (plan.size() > 0) begin
      e = plan.pop_front();
      opcode = e.op;
      mem_ready = e.rdy;
      @(negedge clk);
      n_cmp++;
      if (dut_ctl !== e.c) begin
        n_bad++;
        $display("FAIL %s ctl: got %h want %h (op %b rdy %b)", tag, dut_ctl, e.c, e.op, e.rdy);
      end
      n_cmp++;
      if (retired !== exp_ret) begin
        n_bad++;
        $display("FAIL %s retired: got %0d want %0d", tag, retired, exp_ret);
      end
      n_cmp++;
      if ({trap, trap_cause} !== 3'b000) begin
        n_bad++;
        $display("FAIL %s trap: got %b/%0d want 0/0", tag, trap, trap_cause);
      end
      if (e.c.instr_done) exp_ret++;
      @(posedge clk); #1;
    end
  endtask

  task automatic do_reset();
    clr = 1'b1;
    mem_ready = 1'($urandom);
    @(posedge clk); #1;
    clr = 1'b0;
    exp_ret = '0;
    plan.delete();
  endtask

  task automatic test_reset();
    clr = 1'b1; mem_ready = 1'b1; opcode = 6'($urandom);
    @(posedge clk); #1;
    @(negedge clk);
    n_cmp++;
    if (dut_ctl !== '0 || retired !== '0 || trap !== 1'b0 || trap_cause !== 2'd0) begin
      n_bad++;
      $display("FAIL reset_hold: ctl %h ret %0d trap %b cause %0d want all 0", dut_ctl, retired, trap, trap_cause);
    end
    @(posedge clk); #1;
    clr = 1'b0; mem_ready = 1'b0; exp_ret = '0;
    @(negedge clk);
    n_cmp++;
    if (dut_ctl !== fetch_wait_word()) begin
      n_bad++;
      $display("FAIL reset_fetch: ctl %h want %h", dut_ctl, fetch_wait_word());
    end
    @(posedge clk); #1;
    $display("test_reset done");
  endtask

  task automatic test_r_type();
    do_reset();
    plan_instr(OP_R, 0, 0);
    run_plan("r_type");
    mem_ready = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (retired !== CNTW'(1)) begin
      n_bad++;
      $display("FAIL r_type_retired: got %0d want 1", retired);
    end
    @(posedge clk); #1;
    $display("test_r_type done");
  endtask

  task automatic test_lw_stall();
    do_reset();
    plan_instr(OP_LW, 0, 3);
    run_plan("lw_stall");
    mem_ready = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (retired !== CNTW'(1)) begin
      n_bad++;
      $display("FAIL lw_stall_retired: got %0d want 1", retired);
    end
    @(posedge clk); #1;
    $display("test_lw_stall done");
  endtask

  task automatic test_illegal();
    logic [5:0] op;
    for (int k = 0; k < 4; k++) begin
      do_reset();
      op = 6'b111111;
      if (k > 0) begin
        op = 6'($urandom);
        while (is_legal(op)) op = 6'($urandom);
      end
      plan_instr(op, 0, 0);
      run_plan("illegal");
      for (int i = 0; i < 5; i++) begin
        mem_ready = 1'($urandom);
        opcode = 6'($urandom);
        @(negedge clk);
        n_cmp++;
        if (dut_ctl !== '0 || trap !== 1'b1 || trap_cause !== 2'd1 || retired !== '0) begin
          n_bad++;
          $display("FAIL illegal_trap op %b: ctl %h trap %b cause %0d ret %0d want 0/1/1/0", op, dut_ctl, trap, trap_cause, retired);
        end
        @(posedge clk); #1;
      end
    end
    $display("test_illegal done");
  endtask

  task automatic test_timeout();
    ctl_t c;
    do_reset();
    mem_ready = 1'b0;
    for (int i = 0; i < WAIT_MAX; i++) begin
      @(negedge clk);
      n_cmp++;
      if (dut_ctl !== fetch_wait_word() || trap !== 1'b0) begin
        n_bad++;
        $display("FAIL fetch_wait cyc %0d: ctl %h trap %b want %h 0", i, dut_ctl, trap, fetch_wait_word());
      end
      @(posedge clk); #1;
    end
    for (int i = 0; i < 3; i++) begin
      mem_ready = 1'($urandom);
      @(negedge clk);
      n_cmp++;
      if (dut_ctl !== '0 || trap !== 1'b1 || trap_cause !== 2'd2) begin
        n_bad++;
        $display("FAIL fetch_timeout: ctl %h trap %b cause %0d want 0/1/2", dut_ctl, trap, trap_cause);
      end
      @(posedge clk); #1;
    end
    // Ready on the last allowed cycle must not trap.
    do_reset();
    plan_instr(OP_R, WAIT_MAX - 1, 0);
    run_plan("fetch_edge");
    // Store that never completes.
    do_reset();
    plan_instr(OP_SW, 0, 0);
    void'(plan.pop_back());
    c = '0; c.mem_write = 1'b1; c.i_or_d = 1'b1;
    for (int i = 0; i < WAIT_MAX; i++) add(c, 1'b0, OP_SW);
    run_plan("memwr_wait");
    @(negedge clk);
    n_cmp++;
    if (dut_ctl !== '0 || trap !== 1'b1 || trap_cause !== 2'd2) begin
      n_bad++;
      $display("FAIL memwr_timeout: ctl %h trap %b cause %0d want 0/1/2", dut_ctl, trap, trap_cause);
    end
    @(posedge clk); #1;
    $display("test_timeout done");
  endtask

  task automatic test_back_to_back();
    do_reset();
    plan_instr(OP_BEQ, 0, 0);
    plan_instr(OP_J, 0, 0);
    plan_instr(OP_SW, 0, 0);
    plan_instr(OP_ADDI, 0, 0);
    run_plan("seq");
    mem_ready = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (retired !== CNTW'(4)) begin
      n_bad++;
      $display("FAIL seq_retired: got %0d want 4", retired);
    end
    @(posedge clk); #1;
    $display("test_back_to_back done");
  endtask

  task automatic test_clr_mid_memwr();
    ctl_t c;
    do_reset();
    plan_instr(OP_R, 0, 0);
    plan_instr(OP_SW, 0, 0);
    void'(plan.pop_back());
    c = '0; c.mem_write = 1'b1; c.i_or_d = 1'b1;
    add(c, 1'b0, OP_SW);
    add(c, 1'b0, OP_SW);
    run_plan("clr_pre");
    clr = 1'b1; mem_ready = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (mem_write !== 1'b0 || dut_ctl !== '0 || retired !== '0) begin
      n_bad++;
      $display("FAIL clr_drop: mem_write %b ctl %h ret %0d want 0", mem_write, dut_ctl, retired);
    end
    @(posedge clk); #1;
    clr = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (dut_ctl !== fetch_wait_word() || retired !== '0 || trap !== 1'b0) begin
      n_bad++;
      $display("FAIL clr_after: ctl %h ret %0d trap %b want %h 0 0", dut_ctl, retired, trap, fetch_wait_word());
    end
    @(posedge clk); #1;
    $display("test_clr_mid_memwr done");
  endtask

  task automatic test_random_stream();
    int fd, md;
    do_reset();
    for (int n = 0; n < 120; n++) begin
      fd = ($urandom_range(0, 15) == 0) ? WAIT_MAX - 1 : $urandom_range(0, 3);
      md = ($urandom_range(0, 15) == 0) ? WAIT_MAX - 1 : $urandom_range(0, 3);
      plan_instr(pick_legal(), fd, md);
      run_plan("random");
    end
    $display("test_random_stream done, model retired %0d", exp_ret);
  endtask

  initial begin
    exp_ret = '0;
    test_reset();
    test_r_type();
    test_lw_stall();
    test_illegal();
    test_timeout();
    test_back_to_back();
    test_clr_mid_memwr();
    test_random_stream();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
